// File: rtl/shot_resolver_if.sv
// Shot/result handshake bundle between the turn controller and shot_resolver.
// The master side issues shots and receives the classified result strobe;
// the slave side (the resolver) accepts shots and reports results.
interface shot_resolver_if #(
    parameter int ROWS   = 5,
    parameter int COLS   = 5,
    parameter int CELL_W = 3
);
    localparam int XW = $clog2(ROWS);
    localparam int YW = $clog2(COLS);

    logic              shot_valid;
    logic              shot_ready;
    logic [XW-1:0]     shot_x;
    logic [YW-1:0]     shot_y;
    logic              result_valid;
    logic [1:0]        result;
    logic              sunk;
    logic [CELL_W-1:0] sunk_id;

    modport master (
        output shot_valid, shot_x, shot_y,
        input  shot_ready, result_valid, result, sunk, sunk_id
    );

    modport slave (
        input  shot_valid, shot_x, shot_y,
        output shot_ready, result_valid, result, sunk, sunk_id
    );
endinterface

// File: rtl/shot_resolver.sv
// Battleship shot resolver: holds the ROWS x COLS board, resolves one shot
// every four cycles (IDLE -> LOOKUP -> UPDATE -> REPORT) and tracks how many
// ships are still afloat.
// Optional feature macro: SUNK_REPORT_EN (per-ship counters with sunk/sunk_id
// reporting). Without it a single total-cell counter drives ships_left.
module shot_resolver #(
    parameter int ROWS     = 5,
    parameter int COLS     = 5,
    parameter int CELL_W   = 3,
    parameter int MAX_SHIP = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load,
    input  logic [ROWS*COLS*CELL_W-1:0]     board_in,
    output logic [$clog2(MAX_SHIP+1)-1:0]   ships_left,
    output logic                            game_over,
    output logic [ROWS*COLS*CELL_W-1:0]     board_out,
    shot_resolver_if.slave                  bus
);
    localparam int CELLS  = ROWS * COLS;
    localparam int XW     = $clog2(ROWS);
    localparam int YW     = $clog2(COLS);
    localparam int CIDX_W = $clog2(CELLS);
    localparam int CNT_W  = $clog2(CELLS + 1);
    localparam int SL_W   = $clog2(MAX_SHIP + 1);
    localparam logic [CELL_W-1:0] HIT_CODE  = {{(CELL_W-1){1'b1}}, 1'b0};
    localparam logic [CELL_W-1:0] MISS_CODE = {CELL_W{1'b1}};
    localparam logic [CELL_W-1:0] MAX_ID    = CELL_W'(MAX_SHIP);

    typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, REPORT} state_t;
    typedef enum logic [1:0] {
        RES_MISS   = 2'b00,
        RES_HIT    = 2'b01,
        RES_REPEAT = 2'b10,
        RES_OOR    = 2'b11
    } res_t;

    state_t                        state_q, state_d;
    res_t                          res_q, res_d;
    logic [XW-1:0]                 x_q;
    logic [YW-1:0]                 y_q;
    logic [CELLS-1:0][CELL_W-1:0]  board_q;
    logic [CELLS-1:0][CELL_W-1:0]  board_in_cells;
    logic [CIDX_W-1:0]             cell_idx;
    logic                          in_range;
    logic [CELL_W-1:0]             cell_rd;
    logic                          accept;
    logic                          go_q;

`ifdef SUNK_REPORT_EN
    logic [CNT_W-1:0]  cnt_q    [1:MAX_SHIP];
    logic [CNT_W-1:0]  load_cnt [1:MAX_SHIP];
    logic [CNT_W-1:0]  id_cnt;
    logic [CELL_W-1:0] id_q;
    logic              sunk_q;
    logic              sunk_now;
`else
    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  load_total;
`endif

    assign board_in_cells = board_in;
    assign board_out      = board_q;

    // Latched target is only dereferenced when it lies on the board.
    assign in_range = ({1'b0, x_q} < (XW+1)'(ROWS)) && ({1'b0, y_q} < (YW+1)'(COLS));
    assign cell_idx = CIDX_W'(x_q) * CIDX_W'(COLS) + CIDX_W'(y_q);
    assign cell_rd  = in_range ? board_q[cell_idx] : '0;

    // A pending load owns the IDLE cycle; after game over no further shots.
    assign accept         = bus.shot_valid && bus.shot_ready;
    assign bus.shot_ready = (state_q == IDLE) && !load && !go_q;

    // Classify the latched target from the current cell contents.
    always_comb begin
        res_d = RES_MISS;
        if (!in_range)
            res_d = RES_OOR;
        else if (cell_rd == HIT_CODE || cell_rd == MISS_CODE)
            res_d = RES_REPEAT;
        else if (cell_rd != '0 && cell_rd <= MAX_ID)
            res_d = RES_HIT;
    end

`ifdef SUNK_REPORT_EN
    // Per-id cell counts of an incoming board, plus afloat-ship tally and the count for the shot's id.
    always_comb begin
        for (int i = 1; i <= MAX_SHIP; i++) begin
            load_cnt[i] = '0;
            for (int c = 0; c < CELLS; c++)
                if (board_in_cells[c] == CELL_W'(i))
                    load_cnt[i] = load_cnt[i] + CNT_W'(1);
        end
        ships_left = '0;
        id_cnt     = '0;
        for (int i = 1; i <= MAX_SHIP; i++) begin
            if (cnt_q[i] != '0)
                ships_left = ships_left + SL_W'(1);
            if (id_q == CELL_W'(i))
                id_cnt = cnt_q[i];
        end
    end

    assign sunk_now    = (state_q == REPORT) && sunk_q;
    assign bus.sunk    = sunk_now;
    assign bus.sunk_id = sunk_now ? id_q : '0;
`else
    // Total ship cells of an incoming board and a single afloat flag.
    always_comb begin
        load_total = '0;
        for (int c = 0; c < CELLS; c++)
            if (board_in_cells[c] != '0 && board_in_cells[c] <= MAX_ID)
                load_total = load_total + CNT_W'(1);
        ships_left = (total_q != '0) ? SL_W'(1) : '0;
    end

    assign bus.sunk    = 1'b0;
    assign bus.sunk_id = '0;
`endif

    assign bus.result_valid = (state_q == REPORT);
    assign bus.result       = (state_q == REPORT) ? res_q : RES_MISS;
    assign game_over        = go_q || ((state_q == REPORT) && (res_q == RES_HIT) && (ships_left == '0));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Fixed four-step walk once a shot is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LOOKUP;
            LOOKUP:  state_d = UPDATE;
            UPDATE:  state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Board, counters and shot context; counters stop at zero rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= RES_MISS;
            go_q    <= 1'b0;
`ifdef SUNK_REPORT_EN
            for (int i = 1; i <= MAX_SHIP; i++) cnt_q[i] <= '0;
            id_q   <= '0;
            sunk_q <= 1'b0;
`else
            total_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        board_q <= board_in_cells;
                        go_q    <= 1'b0;
`ifdef SUNK_REPORT_EN
                        for (int i = 1; i <= MAX_SHIP; i++) cnt_q[i] <= load_cnt[i];
`else
                        total_q <= load_total;
`endif
                    end else if (accept) begin
                        x_q <= bus.shot_x;
                        y_q <= bus.shot_y;
                    end
                end
                LOOKUP: begin
                    res_q <= res_d;
`ifdef SUNK_REPORT_EN
                    id_q  <= cell_rd;
`endif
                end
                UPDATE: begin
                    if (res_q == RES_MISS) begin
                        board_q[cell_idx] <= MISS_CODE;
                    end else if (res_q == RES_HIT) begin
                        board_q[cell_idx] <= HIT_CODE;
`ifdef SUNK_REPORT_EN
                        for (int i = 1; i <= MAX_SHIP; i++)
                            if (id_q == CELL_W'(i) && cnt_q[i] != '0)
                                cnt_q[i] <= cnt_q[i] - CNT_W'(1);
`else
                        if (total_q != '0)
                            total_q <= total_q - CNT_W'(1);
`endif
                    end
`ifdef SUNK_REPORT_EN
                    sunk_q <= (res_q == RES_HIT) && (id_cnt == CNT_W'(1));
`endif
                end
                REPORT: begin
                    go_q <= game_over;
`ifdef SUNK_REPORT_EN
                    sunk_q <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shot_resolver.sv
// Self-checking bench for shot_resolver: directed scenarios followed by
// randomized boards and shots. Expected results come from a cell-array model
// of the game rules; a monitor pops them whenever the DUT strobes a result.
module tb_shot_resolver;
    localparam int ROWS     = 5;
    localparam int COLS     = 5;
    localparam int CELL_W   = 3;
    localparam int MAX_SHIP = 5;
    localparam int BW       = ROWS * COLS * CELL_W;
    localparam int HIT_C    = 2**CELL_W - 2;
    localparam int MISS_C   = 2**CELL_W - 1;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          load     = 1'b0;
    logic [BW-1:0] board_in = '0;
    logic [2:0]    ships_left;
    logic          game_over;
    logic [BW-1:0] board_out;

    shot_resolver_if #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W)) bus ();

    shot_resolver #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .MAX_SHIP(MAX_SHIP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .board_in   (board_in),
        .ships_left (ships_left),
        .game_over  (game_over),
        .board_out  (board_out),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    res;
        logic          sunk;
        logic [2:0]    sunk_id;
        logic [2:0]    ships;
        logic          go;
        logic [BW-1:0] board;
        int            edge_no;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   model_board [ROWS][COLS];
    bit   model_go;
    int   checks     = 0;
    int   errors     = 0;
    int   edge_count = 0;
    int   strobes    = 0;

    always @(posedge clk) edge_count <= edge_count + 1;

    task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] model_flat();
        logic [BW-1:0] f;
        f = '0;
        for (int x = 0; x < ROWS; x++)
            for (int y = 0; y < COLS; y++)
                f[(x*COLS+y)*CELL_W +: CELL_W] = CELL_W'(model_board[x][y]);
        return f;
    endfunction

    function automatic void model_load(input logic [BW-1:0] f);
        for (int x = 0; x < ROWS; x++)
            for (int y = 0; y < COLS; y++)
                model_board[x][y] = int'(f[(x*COLS+y)*CELL_W +: CELL_W]);
        model_go = 1'b0;
    endfunction

    function automatic int count_code(input int code);
        int n = 0;
        for (int x = 0; x < ROWS; x++)
            for (int y = 0; y < COLS; y++)
                if (model_board[x][y] == code) n++;
        return n;
    endfunction

    // Ships afloat: distinct ids still on the board (or just "any ship cell" without sunk reporting).
    function automatic logic [2:0] model_ships();
        int n = 0;
        int cells = 0;
        for (int id = 1; id <= MAX_SHIP; id++) begin
            if (count_code(id) > 0) n++;
            cells += count_code(id);
        end
`ifdef SUNK_REPORT_EN
        return 3'(n);
`else
        return (cells > 0) ? 3'd1 : 3'd0;
`endif
    endfunction

    function automatic exp_t model_shot(input int x, input int y);
        exp_t e;
        int   c;
        e.res = 2'd0; e.sunk = 1'b0; e.sunk_id = '0; e.edge_no = 0;
        if (x >= ROWS || y >= COLS) begin
            e.res = 2'd3;
        end else begin
            c = model_board[x][y];
            if (c == HIT_C || c == MISS_C) begin
                e.res = 2'd2;
            end else if (c >= 1 && c <= MAX_SHIP) begin
                e.res = 2'd1;
                model_board[x][y] = HIT_C;
`ifdef SUNK_REPORT_EN
                if (count_code(c) == 0) begin
                    e.sunk    = 1'b1;
                    e.sunk_id = 3'(c);
                end
`endif
                if (model_ships() == 0) model_go = 1'b1;
            end else begin
                model_board[x][y] = MISS_C;
            end
        end
        e.ships = model_ships();
        e.go    = model_go;
        e.board = model_flat();
        return e;
    endfunction

    function automatic logic [BW-1:0] random_board(input bit dense);
        logic [BW-1:0] f;
        int            n;
        f = '0;
        if (dense) begin
            for (int c = 0; c < ROWS*COLS; c++)
                if ($urandom_range(0, 2) != 0)
                    f[c*CELL_W +: CELL_W] = 3'($urandom_range(1, 7));
        end else begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++)
                f[$urandom_range(0, ROWS*COLS-1)*CELL_W +: CELL_W] = 3'($urandom_range(1, MAX_SHIP));
        end
        return f;
    endfunction

    task automatic loadBoard(input logic [BW-1:0] b);
        @(negedge clk);
        load     = 1'b1;
        board_in = b;
        @(negedge clk);
        load = 1'b0;
        model_load(b);
        #1;
    endtask

    // Issue one shot, push its expected result, then wait for the monitor to consume it.
    task automatic applyStimulus(input logic [2:0] x, input logic [2:0] y);
        exp_t e;
        bit   ok;
        @(negedge clk);
        bus.shot_valid = 1'b1;
        bus.shot_x     = x;
        bus.shot_y     = y;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.shot_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("shot_accept", BW'(ok), BW'(1));
        if (ok) begin
            e = model_shot(int'(x), int'(y));
            e.edge_no = edge_count + 3;
            sb.push_back(e);
            @(negedge clk);
            bus.shot_valid = 1'b0;
            bus.shot_x     = 3'($urandom);
            bus.shot_y     = 3'($urandom);
            for (int k = 0; k < 20; k++) begin
                if (sb.size() == 0) break;
                @(negedge clk);
                #1;
            end
            checkOutput("result_drain", BW'(sb.size()), BW'(0));
            sb.delete();
        end else begin
            bus.shot_valid = 1'b0;
        end
    endtask

    // Monitor: every result strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.result_valid === 1'b1) begin
            strobes++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got strobe with result %0d expected no strobe", bus.result);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("latency", BW'(edge_count), BW'(mon_e.edge_no));
                checkOutput("result", BW'(bus.result), BW'(mon_e.res));
                checkOutput("sunk", BW'(bus.sunk), BW'(mon_e.sunk));
                checkOutput("sunk_id", BW'(bus.sunk_id), BW'(mon_e.sunk_id));
                checkOutput("ships_left", BW'(ships_left), BW'(mon_e.ships));
                checkOutput("game_over", BW'(game_over), BW'(mon_e.go));
                checkOutput("board", board_out, mon_e.board);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [BW-1:0] b;
        logic [BW-1:0] nb;
        int            s0;
        logic [2:0]    sx, sy;

        bus.shot_valid = 1'b0;
        bus.shot_x     = '0;
        bus.shot_y     = '0;
        for (int x = 0; x < ROWS; x++)
            for (int y = 0; y < COLS; y++)
                model_board[x][y] = 0;
        model_go = 1'b0;

        // Reset values while rst_n is held low.
        @(negedge clk);
        #1;
        checkOutput("reset_ready", BW'(bus.shot_ready), BW'(1));
        checkOutput("reset_result_valid", BW'(bus.result_valid), BW'(0));
        checkOutput("reset_result", BW'(bus.result), BW'(0));
        checkOutput("reset_sunk", BW'(bus.sunk), BW'(0));
        checkOutput("reset_sunk_id", BW'(bus.sunk_id), BW'(0));
        checkOutput("reset_ships_left", BW'(ships_left), BW'(0));
        checkOutput("reset_game_over", BW'(game_over), BW'(0));
        checkOutput("reset_board", board_out, '0);
        rst_n = 1'b1;

        // Ship 2 on (0,0),(0,1); miss, hit, sinking hit, game over.
        b = '0;
        b[(0*COLS+0)*CELL_W +: CELL_W] = 3'd2;
        b[(0*COLS+1)*CELL_W +: CELL_W] = 3'd2;
        loadBoard(b);
        checkOutput("ships_after_load", BW'(ships_left), BW'(1));
        applyStimulus(3'd4, 3'd4);
        applyStimulus(3'd0, 3'd0);
        applyStimulus(3'd0, 3'd1);
        checkOutput("ready_after_game_over", BW'(bus.shot_ready), BW'(0));
        checkOutput("game_over_sticky", BW'(game_over), BW'(1));

        // Reload clears game over; repeat shot and out-of-range shots.
        loadBoard(b);
        checkOutput("game_over_cleared", BW'(game_over), BW'(0));
        applyStimulus(3'd0, 3'd0);
        applyStimulus(3'd0, 3'd0);
        applyStimulus(3'd5, 3'd2);
        applyStimulus(3'd2, 3'd7);

        // Load and shot in the same IDLE cycle: load wins.
        nb = random_board(1'b1);
        @(negedge clk);
        load           = 1'b1;
        board_in       = nb;
        bus.shot_valid = 1'b1;
        bus.shot_x     = 3'd3;
        bus.shot_y     = 3'd3;
        #1;
        checkOutput("ready_low_during_load", BW'(bus.shot_ready), BW'(0));
        @(negedge clk);
        load           = 1'b0;
        bus.shot_valid = 1'b0;
        model_load(nb);
        s0 = strobes;
        repeat (6) @(negedge clk);
        #1;
        checkOutput("no_result_after_load", BW'(strobes - s0), BW'(0));
        checkOutput("board_after_load", board_out, model_flat());

        // Reset asserted while the shot is in LOOKUP.
        @(negedge clk);
        bus.shot_valid = 1'b1;
        bus.shot_x     = 3'd1;
        bus.shot_y     = 3'd1;
        @(negedge clk);
        bus.shot_valid = 1'b0;
        rst_n          = 1'b0;
        s0 = strobes;
        @(negedge clk);
        rst_n = 1'b1;
        for (int x = 0; x < ROWS; x++)
            for (int y = 0; y < COLS; y++)
                model_board[x][y] = 0;
        model_go = 1'b0;
        #1;
        checkOutput("abort_board_cleared", board_out, '0);
        checkOutput("abort_ready", BW'(bus.shot_ready), BW'(1));
        checkOutput("abort_ships_left", BW'(ships_left), BW'(0));
        repeat (6) @(negedge clk);
        #1;
        checkOutput("abort_no_result", BW'(strobes - s0), BW'(0));

        // Randomized boards and shots, half aimed at remaining ship cells.
        for (int bi = 0; bi < 10; bi++) begin
            loadBoard(random_board(bi[0]));
            for (int s = 0; s < 15; s++) begin
                if (model_go) break;
                sx = 3'($urandom_range(0, 7));
                sy = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 9) < 7) begin
                    sx = 3'($urandom_range(0, ROWS-1));
                    sy = 3'($urandom_range(0, COLS-1));
                end
                if ($urandom_range(0, 1) == 1) begin
                    for (int x = 0; x < ROWS; x++)
                        for (int y = 0; y < COLS; y++)
                            if (model_board[x][y] >= 1 && model_board[x][y] <= MAX_SHIP) begin
                                sx = 3'(x);
                                sy = 3'(y);
                            end
                end
                applyStimulus(sx, sy);
            end
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
